// File: rtl/regfile_pkg.sv
// Shared register-file defaults and types for the 16-bit three-stage core.
// Consumers import this package for the default geometry and address/data types.
package regfile_pkg;

    localparam int ADDR_LEN_DEF      = 3;
    localparam int DATA_WIDTH_DEF    = 16;
    localparam int REG_FILE_SIZE_DEF = 8;

    typedef logic [ADDR_LEN_DEF-1:0]   reg_addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sb_scoreboard.sv
// Write-back scoreboard: one busy bit per register, set on issue, cleared on write or flush.
// Busy and busy_cnt are registered; busy_cnt moves by the exact population change each cycle.
module sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_LEN      = ADDR_LEN_DEF,
    parameter int REG_FILE_SIZE = REG_FILE_SIZE_DEF,
    parameter int NUM_WR        = 2,
    parameter int CNT_W         = cnt_width(REG_FILE_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       iss_en,
    input  logic [ADDR_LEN-1:0]        iss_rd,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_LEN-1:0] wr_addr,
    output logic [REG_FILE_SIZE-1:0]   busy,
    output logic [CNT_W-1:0]           busy_cnt
);

    logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;
    logic [REG_FILE_SIZE-1:0] set_mask, clr_mask, fell_mask;
    logic [CNT_W-1:0]         inc, dec;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_en && iss_rd != '0) begin
            set_mask[iss_rd] = 1'b1;
        end
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*ADDR_LEN +: ADDR_LEN] != '0) begin
                clr_mask[wr_addr[w*ADDR_LEN +: ADDR_LEN]] = 1'b1;
            end
        end

        // A new producer on the written register keeps it busy, so it never "falls".
        fell_mask = busy_q & clr_mask & ~set_mask;
        dec = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            dec = dec + CNT_W'(fell_mask[i]);
        end
        inc = CNT_W'(|(set_mask & ~busy_q));

        if (flush) begin
            busy_d     = '0;
            busy_cnt_d = '0;
        end else begin
            busy_d     = (busy_q & ~clr_mask) | set_mask;
            busy_cnt_d = busy_cnt_q + inc - dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/sb_reg_file.sv
// Multi-port register file with write-back scoreboard; combinational reads, writes commit at the edge.
// Define SB_REG_FILE_BYPASS_EN to forward same-cycle write data (and busy clear) onto matching reads.
module sb_reg_file
    import regfile_pkg::*;
#(
    parameter int ADDR_LEN      = ADDR_LEN_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int REG_FILE_SIZE = REG_FILE_SIZE_DEF,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 2
) (
    input  logic                                  clk,
    input  logic                                  Reset,
    input  logic [NUM_WR-1:0]                     Wr_En,
    input  logic [NUM_WR*ADDR_LEN-1:0]            Wr_Addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]          Wr_Data,
    input  logic [NUM_RD*ADDR_LEN-1:0]            Rd_Addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]          Rd_Data,
    output logic [NUM_RD-1:0]                     Rd_Busy,
    input  logic                                  Iss_En,
    input  logic [ADDR_LEN-1:0]                   Iss_Rd,
    input  logic                                  Flush,
    output logic [REG_FILE_SIZE-1:0]              Busy,
    output logic [$clog2(REG_FILE_SIZE+1)-1:0]    Busy_Cnt
);

    localparam int CNT_W = $clog2(REG_FILE_SIZE + 1);

    logic [DATA_WIDTH-1:0] mem_q [REG_FILE_SIZE];
    logic [DATA_WIDTH-1:0] mem_d [REG_FILE_SIZE];
    logic [ADDR_LEN-1:0]   rd_addr_cur;
    logic [DATA_WIDTH-1:0] rd_data_cur;
    logic                  rd_busy_cur;

    sb_scoreboard #(
        .ADDR_LEN      (ADDR_LEN),
        .REG_FILE_SIZE (REG_FILE_SIZE),
        .NUM_WR        (NUM_WR),
        .CNT_W         (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (Reset),
        .flush    (Flush),
        .iss_en   (Iss_En),
        .iss_rd   (Iss_Rd),
        .wr_en    (Wr_En),
        .wr_addr  (Wr_Addr),
        .busy     (Busy),
        .busy_cnt (Busy_Cnt)
    );

    // Ports are applied in ascending order so the highest-index port wins a collision.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (Wr_En[w] && Wr_Addr[w*ADDR_LEN +: ADDR_LEN] != '0) begin
                mem_d[Wr_Addr[w*ADDR_LEN +: ADDR_LEN]] = Wr_Data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // r0 is never written and never busy, so stored state alone makes it read as zero.
    always_comb begin
        Rd_Data     = '0;
        Rd_Busy     = '0;
        rd_addr_cur = '0;
        rd_data_cur = '0;
        rd_busy_cur = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_addr_cur = Rd_Addr[r*ADDR_LEN +: ADDR_LEN];
            rd_data_cur = mem_q[rd_addr_cur];
            rd_busy_cur = Busy[rd_addr_cur];
`ifdef SB_REG_FILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (Wr_En[w] && Wr_Addr[w*ADDR_LEN +: ADDR_LEN] != '0 &&
                    Wr_Addr[w*ADDR_LEN +: ADDR_LEN] == rd_addr_cur) begin
                    rd_data_cur = Wr_Data[w*DATA_WIDTH +: DATA_WIDTH];
                    rd_busy_cur = Iss_En && (Iss_Rd == rd_addr_cur);
                end
            end
`endif
            if (!Reset) begin
                Rd_Data[r*DATA_WIDTH +: DATA_WIDTH] = rd_data_cur;
                Rd_Busy[r]                          = rd_busy_cur;
            end
        end
    end

endmodule

// File: tb/tb_sb_reg_file.sv
// Directed scoreboard bench for sb_reg_file; expected values follow SB_REG_FILE_BYPASS_EN when defined.
module tb_sb_reg_file;
    import regfile_pkg::*;

    localparam int K_RD_DATA = 0;
    localparam int K_RD_BUSY = 1;
    localparam int K_BUSY    = 2;
    localparam int K_CNT     = 3;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  Wr_En = '0;
    logic [5:0]  Wr_Addr = '0;
    logic [31:0] Wr_Data = '0;
    logic [5:0]  Rd_Addr = '0;
    logic [31:0] Rd_Data;
    logic [1:0]  Rd_Busy;
    logic        Iss_En = 1'b0;
    reg_addr_t   Iss_Rd = '0;
    logic        Flush = 1'b0;
    logic [7:0]  Busy;
    logic [3:0]  Busy_Cnt;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    exp_t e;
    logic [31:0] act;
    logic        byp;

    sb_reg_file dut (
        .clk      (clk),
        .Reset    (Reset),
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_Data  (Wr_Data),
        .Rd_Addr  (Rd_Addr),
        .Rd_Data  (Rd_Data),
        .Rd_Busy  (Rd_Busy),
        .Iss_En   (Iss_En),
        .Iss_Rd   (Iss_Rd),
        .Flush    (Flush),
        .Busy     (Busy),
        .Busy_Cnt (Busy_Cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every expectation stamped for the current cycle at the falling edge.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            case (e.kind)
                K_RD_DATA: act = {16'h0, Rd_Data[e.port*16 +: 16]};
                K_RD_BUSY: act = {31'h0, Rd_Busy[e.port]};
                K_BUSY:    act = {24'h0, Busy};
                default:   act = {28'h0, Busy_Cnt};
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, e.cyc, act, e.val);
            end
        end
    end

    task automatic ex(input int kind, input int port, input logic [31:0] val, input string name);
        expq.push_back('{cyc: cyc, kind: kind, port: port, val: val, name: name});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        Wr_En  = '0;
        Iss_En = 1'b0;
        Flush  = 1'b0;
    endtask

    task automatic wr(input int port, input logic [2:0] addr, input logic [15:0] data);
        Wr_En[port]            = 1'b1;
        Wr_Addr[port*3 +: 3]   = addr;
        Wr_Data[port*16 +: 16] = data;
    endtask

    task automatic iss(input logic [2:0] addr);
        Iss_En = 1'b1;
        Iss_Rd = addr;
    endtask

    task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
        Rd_Addr = {a1, a0};
    endtask

    initial begin
`ifdef SB_REG_FILE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        step(); step();
        ex(K_BUSY, 0, 32'h0, "reset_busy");
        ex(K_CNT, 0, 32'h0, "reset_cnt");

        // Reset mid-run
        step(); Reset = 1'b0; rd(3'd3, 3'd5);
        ex(K_RD_DATA, 0, 32'h0, "idle_r3");
        step(); wr(0, 3'd3, 16'h1234); iss(3'd5);
        ex(K_RD_DATA, 0, byp ? 32'h1234 : 32'h0, "r3_same_cycle");
        ex(K_RD_BUSY, 1, 32'h0, "r5_not_yet_busy");
        step();
        ex(K_RD_DATA, 0, 32'h1234, "r3_written");
        ex(K_RD_BUSY, 1, 32'h1, "r5_busy");
        ex(K_BUSY, 0, 32'h20, "busy_r5");
        ex(K_CNT, 0, 32'h1, "cnt_r5");
        step(); Reset = 1'b1; iss(3'd5);
        ex(K_RD_DATA, 0, 32'h0, "reset_rd_data");
        ex(K_RD_BUSY, 1, 32'h0, "reset_rd_busy");
        ex(K_BUSY, 0, 32'h0, "reset_mid_busy");
        ex(K_CNT, 0, 32'h0, "reset_mid_cnt");
        step(); Reset = 1'b0;
        ex(K_RD_DATA, 0, 32'h0, "r3_cleared");
        ex(K_BUSY, 0, 32'h0, "busy_after_reset");

        // Dual write conflict
        step(); rd(3'd2, 3'd0); wr(0, 3'd2, 16'hAAAA); wr(1, 3'd2, 16'h5555);
        ex(K_RD_DATA, 0, byp ? 32'h5555 : 32'h0, "conflict_same_cycle");
        step();
        ex(K_RD_DATA, 0, 32'h5555, "conflict_port1_wins");

        // r0 protection
        step(); rd(3'd0, 3'd2); wr(0, 3'd0, 16'hFFFF); iss(3'd0);
        ex(K_RD_DATA, 0, 32'h0, "r0_same_cycle");
        ex(K_RD_BUSY, 0, 32'h0, "r0_busy_same_cycle");
        step();
        ex(K_RD_DATA, 0, 32'h0, "r0_reads_zero");
        ex(K_BUSY, 0, 32'h0, "r0_never_busy");
        ex(K_CNT, 0, 32'h0, "r0_cnt");

        // Scoreboard
        step(); rd(3'd0, 3'd4); iss(3'd4);
        step(); wr(0, 3'd4, 16'h0011); iss(3'd4);
        ex(K_BUSY, 0, 32'h10, "busy_r4");
        ex(K_CNT, 0, 32'h1, "cnt_r4");
        ex(K_RD_BUSY, 1, 32'h1, "rd_busy_r4_reissue");
        ex(K_RD_DATA, 1, byp ? 32'h0011 : 32'h0, "r4_bypass_reissue");
        step(); wr(1, 3'd4, 16'h0042);
        ex(K_BUSY, 0, 32'h10, "r4_stays_busy");
        ex(K_CNT, 0, 32'h1, "r4_cnt_stays");
        ex(K_RD_DATA, 1, byp ? 32'h0042 : 32'h0011, "r4_plain_write_cycle");
        ex(K_RD_BUSY, 1, byp ? 32'h0 : 32'h1, "r4_busy_plain_write_cycle");
        step();
        ex(K_BUSY, 0, 32'h0, "r4_cleared");
        ex(K_CNT, 0, 32'h0, "r4_cnt_zero");
        ex(K_RD_DATA, 1, 32'h0042, "r4_reads_42");
        ex(K_RD_BUSY, 1, 32'h0, "r4_rd_busy_clear");

        // Flush
        step(); iss(3'd1);
        step(); iss(3'd2);
        step(); iss(3'd6);
        step(); Flush = 1'b1; iss(3'd7);
        ex(K_BUSY, 0, 32'h46, "busy_r1_r2_r6");
        ex(K_CNT, 0, 32'h3, "cnt_three");
        step();
        ex(K_BUSY, 0, 32'h0, "flush_busy");
        ex(K_CNT, 0, 32'h0, "flush_cnt");

        // Two clears in one cycle
        step(); iss(3'd1);
        step(); iss(3'd3);
        step(); rd(3'd1, 3'd3); wr(0, 3'd1, 16'h0101); wr(1, 3'd3, 16'h0303);
        ex(K_BUSY, 0, 32'h0A, "busy_r1_r3");
        ex(K_CNT, 0, 32'h2, "cnt_two");
        step();
        ex(K_BUSY, 0, 32'h0, "double_clear_busy");
        ex(K_CNT, 0, 32'h0, "double_clear_cnt");
        ex(K_RD_DATA, 0, 32'h0101, "r1_data");
        ex(K_RD_DATA, 1, 32'h0303, "r3_data");

        // Write commits during flush
        step(); iss(3'd6);
        step(); rd(3'd6, 3'd3); Flush = 1'b1; wr(0, 3'd6, 16'h6666);
        ex(K_BUSY, 0, 32'h40, "busy_r6");
        ex(K_CNT, 0, 32'h1, "cnt_r6");
        step(); iss(3'd5);
        ex(K_BUSY, 0, 32'h0, "flush_write_busy");
        ex(K_RD_DATA, 0, 32'h6666, "flush_write_commits");

        // Bypass
        step(); rd(3'd5, 3'd3); wr(1, 3'd5, 16'hBEEF);
        ex(K_BUSY, 0, 32'h20, "busy_r5_again");
        ex(K_CNT, 0, 32'h1, "cnt_r5_again");
        ex(K_RD_DATA, 0, byp ? 32'hBEEF : 32'h0, "bypass_data");
        ex(K_RD_BUSY, 0, byp ? 32'h0 : 32'h1, "bypass_busy");
        step();
        ex(K_RD_DATA, 0, 32'hBEEF, "r5_beef");
        ex(K_RD_BUSY, 0, 32'h0, "r5_not_busy");
        ex(K_BUSY, 0, 32'h0, "final_busy");
        ex(K_CNT, 0, 32'h0, "final_cnt");

        step(); step();
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expectations: got %0d pending, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
